// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder controller. Adds two TOTAL-bit operands by stepping one
// shared CHUNK-bit carry-lookahead stage over NUM_CHUNKS cycles, least
// significant chunk first, with the inter-chunk carry held in a register.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      request an addition (sampled only when idle)
//   i_op_a/b     addends, captured on an accepted start
//   i_carry_in   carry into chunk 0, captured on an accepted start
//   o_busy       high while running or signalling done
//   o_done       one-cycle pulse; results valid from this cycle
//   o_result     sum, held between operations
//   o_carry_out  carry out of the top chunk
//   o_overflow   two's-complement overflow of the full-width add
//   o_zero       o_result == 0
module multiword_add_sequencer #(
  parameter int unsigned CHUNK      = 8,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [CHUNK*NUM_CHUNKS-1:0] i_op_a,
  input  logic [CHUNK*NUM_CHUNKS-1:0] i_op_b,
  input  logic                        i_carry_in,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [CHUNK*NUM_CHUNKS-1:0] o_result,
  output logic                        o_carry_out,
  output logic                        o_overflow,
  output logic                        o_zero
);

  localparam int unsigned Total = CHUNK * NUM_CHUNKS;
  localparam int unsigned IdxW  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [Total-1:0]       op_a_q, op_a_d;
  logic [Total-1:0]       op_b_q, op_b_d;
  logic [Total-1:0]       work_q, work_d;
  logic [Total-1:0]       result_q, result_d;
  logic                   carry_out_q, carry_out_d;
  logic                   overflow_q, overflow_d;
  logic                   zero_q, zero_d;

  // Chunk datapath: select the current slice by shifting, then lookahead add.
  logic [31:0]            base;
  logic [Total-1:0]       a_shift, b_shift;
  logic [CHUNK-1:0]       a_chunk, b_chunk, gen, prop, sum;
  logic [CHUNK:0]         c;
  logic [Total-1:0]       chunk_mask;

  always_comb begin
    base       = 32'(idx_q) * CHUNK;
    a_shift    = op_a_q >> base;
    b_shift    = op_b_q >> base;
    a_chunk    = a_shift[CHUNK-1:0];
    b_chunk    = b_shift[CHUNK-1:0];
    gen        = a_chunk & b_chunk;
    prop       = a_chunk | b_chunk;
    c          = '0;
    c[0]       = carry_q;
    for (int i = 0; i < int'(CHUNK); i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    // P = a|b still yields the right sum when combined with a^b below.
    sum        = a_chunk ^ b_chunk ^ c[CHUNK-1:0];
    chunk_mask = {{(Total-CHUNK){1'b0}}, {CHUNK{1'b1}}} << base;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    work_d      = work_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          op_a_d  = i_op_a;
          op_b_d  = i_op_b;
          carry_d = i_carry_in;
          idx_d   = '0;
          work_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d  = (work_q & ~chunk_mask) | ((Total'(sum) << base) & chunk_mask);
        carry_d = c[CHUNK];
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          idx_d       = '0;
          state_d     = StDone;
          result_d    = work_d;
          carry_out_d = c[CHUNK];
          overflow_d  = (op_a_q[Total-1] == op_b_q[Total-1]) &&
                        (work_d[Total-1] != op_a_q[Total-1]);
          zero_d      = (work_d == '0);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      work_q      <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      work_q      <= work_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StDone);
  assign o_result    = result_q;
  assign o_carry_out = carry_out_q;
  assign o_overflow  = overflow_q;
  assign o_zero      = zero_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer at default parameters (8 x 4).
module tb_multiword_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        cin;
  logic        busy, done, carry_out, overflow, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.CHUNK(8), .NUM_CHUNKS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_carry_in  (cin),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result),
    .o_carry_out (carry_out),
    .o_overflow  (overflow),
    .o_zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] r, input logic co,
                            input logic ov, input logic z);
    check({tag, "_result"}, 64'(result), 64'(r));
    check({tag, "_carry"}, 64'(carry_out), 64'(co));
    check({tag, "_ovf"}, 64'(overflow), 64'(ov));
    check({tag, "_zero"}, 64'(zero), 64'(z));
  endtask

  // Issue a start, then return the number of negedges after the accepting
  // edge until done is seen (0 = cycle right after that edge); 99 on timeout.
  task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         output int lat);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 99;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat;
  int done_cnt;
  int done_pos [2];
  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("idle_no_done", 64'(done_cnt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Full-width carry ripple
    run_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ripple_latency", 64'(lat), 64'd4);
    check_outs("ripple", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    check("ripple_busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    check("done_single_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);

    // Signed overflow
    run_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ovf_latency", 64'(lat), 64'd4);
    check_outs("ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // Carry-in path
    run_add(32'h1234_5678, 32'h1111_1111, 1'b1, lat);
    check("cin_latency", 64'(lat), 64'd4);
    check_outs("cin", 32'h2345_678A, 1'b0, 1'b0, 1'b0);

    // Handshake: start held through RUN and DONE with new operands, which also
    // changes op_a mid-run. First add 0x10+0x20; the held start is accepted at
    // the first idle edge, producing 0x01000005.
    held = result;
    @(negedge clk);
    op_a  = 32'h0000_0010;
    op_b  = 32'h0000_0020;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 32'h0100_0000;
    op_b = 32'h0000_0005;
    done_cnt = 0;
    done_pos[0] = -1;
    done_pos[1] = -1;
    for (int i = 0; i <= 12; i++) begin
      if (i == 1) check("hold_result_in_run", 64'(result), 64'(held));
      if (i == 6) start = 1'b0;
      if (done) begin
        if (done_cnt < 2) done_pos[done_cnt] = i;
        done_cnt++;
        if (done_cnt == 1) check_outs("hs_first", 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        if (done_cnt == 2) check_outs("hs_second", 32'h0100_0005, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
    end
    check("hs_done_count", 64'(done_cnt), 64'd2);
    check("hs_first_pos", 64'(done_pos[0]), 64'd4);
    check("hs_second_pos", 64'(done_pos[1]), 64'd10);

    // Reset mid-operation at chunk index 2
    @(negedge clk);
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs("midrst", 32'h0, 1'b0, 1'b0, 1'b0);
    check("midrst_busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    run_add(32'h0000_0003, 32'h0000_0004, 1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check_outs("post_rst", 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
